// File: rtl/wash_sequencer.sv
// Wash program sequencer: runs fill/wash/drain/rinse/spin as timed phases after a start edge,
// with pause/resume, a DONE beep state and a BCD countdown of the total remaining seconds.
`timescale 1ns/1ps
module wash_sequencer #(
  parameter int TICK_DIV = 100000000,
  parameter int FILL_S   = 5,
  parameter int WASH_S1  = 20,
  parameter int WASH_S2  = 40,
  parameter int WASH_S3  = 60,
  parameter int DRAIN_S  = 5,
  parameter int RINSE_S  = 10,
  parameter int SPIN_S   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        p_pos,
  output logic        busy,
  output logic        done,
  output logic        beep,
  output logic        valve_in,
  output logic        valve_out,
  output logic        motor,
  output logic [7:0]  phase_light,
  output logic [11:0] rem_bcd
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // State codes double as the one-hot phase light pattern.
  typedef enum logic [7:0] {
    S_IDLE  = 8'b0000_0001,
    S_DONE  = 8'b0000_0010,
    S_PAUSE = 8'b0000_0100,
    S_SPIN  = 8'b0000_1000,
    S_RINSE = 8'b0001_0000,
    S_DRAIN = 8'b0010_0000,
    S_WASH  = 8'b0100_0000,
    S_FILL  = 8'b1000_0000
  } state_t;

  function automatic logic [11:0] to_bcd(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (v == 12'h000) return 12'h000;
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  function automatic logic [6:0] phase_secs(input state_t s, input logic [1:0] m);
    logic [6:0] r;
    case (s)
      S_FILL:  r = 7'(FILL_S);
      S_WASH: begin
        case (m)
          2'b10:   r = 7'(WASH_S2);
          2'b11:   r = 7'(WASH_S3);
          default: r = 7'(WASH_S1);
        endcase
      end
      S_DRAIN: r = 7'(DRAIN_S);
      S_RINSE: r = 7'(RINSE_S);
      S_SPIN:  r = 7'(SPIN_S);
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  function automatic state_t next_phase(input state_t s);
    state_t r;
    case (s)
      S_FILL:  r = S_WASH;
      S_WASH:  r = S_DRAIN;
      S_DRAIN: r = S_RINSE;
      S_RINSE: r = S_SPIN;
      default: r = S_DONE;
    endcase
    return r;
  endfunction

  localparam int TOT_COMMON = FILL_S + DRAIN_S + RINSE_S + SPIN_S;
  localparam logic [11:0] TOT_M0 = to_bcd(SPIN_S);
  localparam logic [11:0] TOT_M1 = to_bcd(TOT_COMMON + WASH_S1);
  localparam logic [11:0] TOT_M2 = to_bcd(TOT_COMMON + WASH_S2);
  localparam logic [11:0] TOT_M3 = to_bcd(TOT_COMMON + WASH_S3);

  state_t          r_state;
  state_t          w_next;
  state_t          r_saved;
  logic            r_done_d;
  logic            r_start_d;
  logic [1:0]      r_mode;
  logic [PW-1:0]   r_presc;
  logic [6:0]      r_cnt;
  logic [11:0]     r_rem;

  logic            w_start_edge;
  logic            w_prog;
  logic            w_tick;
  state_t          w_first;
  logic [11:0]     w_total;

  assign w_start_edge = start & ~r_start_d;
  assign w_prog = (r_state == S_FILL) || (r_state == S_WASH) || (r_state == S_DRAIN) ||
                  (r_state == S_RINSE) || (r_state == S_SPIN);
  assign w_tick = w_prog && (r_presc == PW'(TICK_DIV - 1));
  assign w_first = (mode == 2'b00) ? S_SPIN : S_FILL;

  always_comb begin
    case (mode)
      2'b00:   w_total = TOT_M0;
      2'b01:   w_total = TOT_M1;
      2'b10:   w_total = TOT_M2;
      default: w_total = TOT_M3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_done_d <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_done_d <= (r_state == S_DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_next = w_first;
      S_PAUSE: if (p_pos) w_next = r_saved;
      S_DONE:  if (p_pos) w_next = S_IDLE;
      default: begin
        // A pause request wins over a coincident tick.
        if (p_pos)
          w_next = S_PAUSE;
        else if (w_tick && (r_cnt == 7'd1))
          w_next = next_phase(r_state);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_mode    <= 2'b00;
      r_saved   <= S_IDLE;
      r_presc   <= '0;
      r_cnt     <= 7'd0;
      r_rem     <= 12'h000;
    end else begin
      r_start_d <= start;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_mode  <= mode;
            r_presc <= '0;
            r_cnt   <= phase_secs(w_first, mode);
            r_rem   <= w_total;
          end
        end
        S_PAUSE: ;
        S_DONE: if (p_pos) r_rem <= 12'h000;
        default: begin
          if (p_pos) begin
            r_saved <= r_state;
          end else if (w_tick) begin
            r_presc <= '0;
            r_rem   <= bcd_dec(r_rem);
            // Load the following phase on the same edge so phases run back to back.
            if (r_cnt == 7'd1)
              r_cnt <= phase_secs(next_phase(r_state), r_mode);
            else
              r_cnt <= r_cnt - 7'd1;
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    phase_light = r_state;
    busy        = w_prog || (r_state == S_PAUSE);
    done        = (r_state == S_DONE) && !r_done_d;
    beep        = (r_state == S_DONE);
    valve_in    = (r_state == S_FILL) || (r_state == S_RINSE);
    valve_out   = (r_state == S_DRAIN) || (r_state == S_SPIN);
    motor       = (r_state == S_WASH) || (r_state == S_RINSE) || (r_state == S_SPIN);
  end

  assign rem_bcd = r_rem;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a 4-cycle tick; expected values are hand-derived.
`timescale 1ns/1ps
module tb_wash_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic        p_pos;
  logic        busy;
  logic        done;
  logic        beep;
  logic        valve_in;
  logic        valve_out;
  logic        motor;
  logic [7:0]  phase_light;
  logic [11:0] rem_bcd;

  int n_vec = 0;
  int n_err = 0;

  wash_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .p_pos(p_pos),
    .busy(busy), .done(done), .beep(beep), .valve_in(valve_in),
    .valve_out(valve_out), .motor(motor), .phase_light(phase_light),
    .rem_bcd(rem_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_p();
    p_pos = 1'b1;
    step(1);
    p_pos = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; p_pos = 1'b0;
    #2;
    chk("rst_light", 32'(phase_light), 32'h01);
    chk("rst_rem", 32'(rem_bcd), 32'h000);
    chk("rst_outs", 32'({busy, done, beep, valve_in, valve_out, motor}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);

    // Mode 01 full run
    mode = 2'b01; start = 1'b1; step(1);
    chk("m1_busy", 32'(busy), 32'h1);
    chk("m1_light_fill", 32'(phase_light), 32'h80);
    chk("m1_rem_start", 32'(rem_bcd), 32'h050);
    chk("m1_valve_in", 32'(valve_in), 32'h1);
    step(19);
    chk("m1_fill_last", 32'(phase_light), 32'h80);
    chk("m1_rem_046", 32'(rem_bcd), 32'h046);
    step(1);
    chk("m1_light_wash", 32'(phase_light), 32'h40);
    chk("m1_rem_045", 32'(rem_bcd), 32'h045);
    step(179);
    chk("m1_pre_done_light", 32'(phase_light), 32'h08);
    chk("m1_pre_done_rem", 32'(rem_bcd), 32'h001);
    chk("m1_pre_done_pulse", 32'(done), 32'h0);
    step(1);
    chk("m1_done_pulse", 32'(done), 32'h1);
    chk("m1_done_light", 32'(phase_light), 32'h02);
    chk("m1_done_busy_beep", 32'({busy, beep}), 32'b01);
    chk("m1_done_rem", 32'(rem_bcd), 32'h000);
    step(1);
    chk("m1_done_once", 32'({done, beep}), 32'b01);
    pulse_p();
    chk("m1_idle", 32'(phase_light), 32'h01);
    step(3);
    chk("held_start_no_restart", 32'(phase_light), 32'h01);
    pulse_p();
    chk("idle_ppos_ignored", 32'(phase_light), 32'h01);

    // Mode 00 spin only
    start = 1'b0; mode = 2'b00; step(1);
    start = 1'b1; step(1);
    chk("m0_light_spin", 32'(phase_light), 32'h08);
    chk("m0_mot_vout_vin", 32'({motor, valve_out, valve_in}), 32'b110);
    chk("m0_rem_start", 32'(rem_bcd), 32'h010);
    step(39);
    chk("m0_pre_done", 32'({phase_light, rem_bcd}), 32'h08001);
    step(1);
    chk("m0_done", 32'({done, phase_light}), 32'h102);
    step(5);
    chk("m0_beep_hold", 32'(beep), 32'h1);
    pulse_p();
    chk("m0_idle", 32'({beep, phase_light}), 32'h001);

    // Mode 11 with pause during wash
    start = 1'b0; mode = 2'b11; step(1);
    start = 1'b1; step(1);
    chk("m3_rem_start", 32'(rem_bcd), 32'h090);
    step(76);
    chk("m3_wash_071", 32'({phase_light, rem_bcd}), 32'h40071);
    p_pos = 1'b1; step(1); p_pos = 1'b0;
    chk("m3_pause_light", 32'(phase_light), 32'h04);
    chk("m3_pause_outs", 32'({motor, valve_in, valve_out, busy}), 32'b0001);
    chk("m3_pause_rem", 32'(rem_bcd), 32'h071);
    mode = 2'b00;
    step(100);
    chk("m3_pause_hold", 32'({phase_light, rem_bcd}), 32'h04071);
    pulse_p();
    chk("m3_resume", 32'({motor, phase_light, rem_bcd}), 32'h140071);
    step(283);
    chk("m3_pre_done", 32'({phase_light, rem_bcd}), 32'h08001);
    step(1);
    chk("m3_done", 32'(done), 32'h1);
    pulse_p();
    chk("m3_idle", 32'(phase_light), 32'h01);

    // Mode 10 BCD borrow and saturation
    start = 1'b0; mode = 2'b10; step(1);
    start = 1'b1; step(1);
    chk("m2_rem_070", 32'(rem_bcd), 32'h070);
    step(3);
    chk("m2_rem_070_hold", 32'(rem_bcd), 32'h070);
    step(1);
    chk("m2_rem_069", 32'(rem_bcd), 32'h069);
    step(36);
    chk("m2_rem_060", 32'(rem_bcd), 32'h060);
    step(4);
    chk("m2_rem_059", 32'(rem_bcd), 32'h059);
    step(196);
    chk("m2_rem_010", 32'(rem_bcd), 32'h010);
    step(4);
    chk("m2_rem_009", 32'(rem_bcd), 32'h009);
    step(36);
    chk("m2_done", 32'({done, rem_bcd}), 32'h1000);
    start = 1'b0; step(1);
    start = 1'b1; step(1);
    chk("m2_start_in_done", 32'(phase_light), 32'h02);
    step(20);
    chk("m2_no_wrap", 32'({beep, rem_bcd}), 32'h1000);
    pulse_p();
    chk("m2_idle", 32'({phase_light, rem_bcd}), 32'h01000);

    // Pause coinciding with a tick, then async reset mid-rinse
    start = 1'b0; mode = 2'b01; step(1);
    start = 1'b1; step(1);
    step(3);
    p_pos = 1'b1; step(1); p_pos = 1'b0;
    chk("tick_pause_light", 32'(phase_light), 32'h04);
    chk("tick_pause_rem", 32'(rem_bcd), 32'h050);
    step(10);
    chk("tick_pause_hold", 32'(rem_bcd), 32'h050);
    pulse_p();
    chk("tick_resume", 32'({phase_light, rem_bcd}), 32'h80050);
    step(135);
    chk("rinse_light", 32'(phase_light), 32'h10);
    chk("rinse_outs", 32'({valve_in, motor, valve_out}), 32'b110);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_light", 32'(phase_light), 32'h01);
    chk("async_rst_rem", 32'(rem_bcd), 32'h000);
    chk("async_rst_outs", 32'({busy, done, beep, valve_in, valve_out, motor}), 32'h0);
    start = 1'b0;
    #3;
    rst = 1'b0;
    step(1);
    chk("post_rst_idle", 32'(phase_light), 32'h01);
    start = 1'b1; step(1);
    chk("post_rst_fill", 32'({phase_light, rem_bcd}), 32'h80050);
    step(20);
    chk("post_rst_wash", 32'({phase_light, rem_bcd}), 32'h40045);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
